// File: rtl/score_pkg.sv
// Shared types and constants for the score overlay writer: FSM state encoding,
// default display register addresses and BCD digit limits.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_DIGIT = 2'd1,
    WR_X     = 2'd2,
    WR_Y     = 2'd3
  } wr_state_t;

  localparam logic [8:0] SCORE_ADDR   = 9'd10;
  localparam logic [8:0] SCORE_X_ADDR = 9'd11;
  localparam logic [8:0] SCORE_Y_ADDR = 9'd12;

  localparam int                 DIGIT_W   = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/score_writer_bcd_digit.sv
// One BCD digit (0..9) with increment-in, carry-out and synchronous clear.
// SCORE_SATURATE_EN adds a saturate input that blocks increments.
module bcd_digit
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               inc_in,
  input  logic               clr,
`ifdef SCORE_SATURATE_EN
  input  logic               saturate,
`endif
  output logic               carry_out,
  output logic [DIGIT_W-1:0] value,
  output logic [DIGIT_W-1:0] value_next
);

  logic step;

`ifdef SCORE_SATURATE_EN
  assign step = inc_in & ~saturate;
`else
  assign step = inc_in;
`endif

  assign carry_out = step & (value == DIGIT_MAX);

  // value_next is exported so the writer can register the post-update digit
  always_comb begin
    value_next = value;
    if (clr) begin
      value_next = '0;
    end else if (step) begin
      value_next = (value == DIGIT_MAX) ? '0 : value + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/score_writer.sv
// Frame-driven BCD score counter that writes digit, X and Y overlay registers
// to the display block once per vsync falling edge. Build option: SCORE_SATURATE_EN.
module score_writer
  import score_pkg::*;
#(
  parameter int unsigned FRAMES_PER_POINT = 6,
  parameter logic [7:0]  SCORE_X          = 8'd8,
  parameter logic [7:0]  SCORE_Y          = 8'd8,
  parameter logic [8:0]  BASE_ADDR        = SCORE_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vsync,
  input  logic        run,
  input  logic        clr,
  output logic        chipselect,
  output logic        write,
  output logic [8:0]  address,
  output logic [31:0] writedata,
  output logic [15:0] score_bcd,
  output logic        busy
);

  localparam logic [7:0] FC_LAST = 8'(FRAMES_PER_POINT - 1);

  logic        vsync_q;
  logic        tick;
  logic        point;
  logic [7:0]  frame_cnt;
  logic        saturate;
  logic [4:0]  carry;
  logic [3:0]  digit_next [4];
  wr_state_t   state;
  wr_state_t   state_next;
  logic        cs_d;
  logic [8:0]  addr_d;
  logic [31:0] data_d;

  // vsync_q resets high so a vsync held high across reset gives no tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= vsync;
    end
  end

  assign tick  = vsync_q & ~vsync;
  assign point = tick & run & (frame_cnt == FC_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else if (clr) begin
      frame_cnt <= '0;
    end else if (tick && run) begin
      frame_cnt <= (frame_cnt == FC_LAST) ? 8'd0 : frame_cnt + 8'd1;
    end
  end

  assign saturate = (score_bcd == 16'h9999);
  assign carry[0] = point;

  for (genvar g = 0; g < 4; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .reset_n    (reset_n),
      .inc_in     (carry[g]),
      .clr        (clr),
`ifdef SCORE_SATURATE_EN
      .saturate   (saturate),
`endif
      .carry_out  (carry[g+1]),
      .value      (score_bcd[4*g +: 4]),
      .value_next (digit_next[g])
    );
  end

  // Ticks outside IDLE are ignored, so a burst is never restarted or stretched
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (tick) state_next = WR_DIGIT;
      WR_DIGIT: state_next = WR_X;
      WR_X:     state_next = WR_Y;
      default:  state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state; the digit write uses the
  // post-update ones digit so a score change or clear in the tick cycle shows.
  always_comb begin
    cs_d   = 1'b0;
    addr_d = '0;
    data_d = '0;
    case (state_next)
      WR_DIGIT: begin
        cs_d   = 1'b1;
        addr_d = BASE_ADDR;
        data_d = {28'b0, digit_next[0]};
      end
      WR_X: begin
        cs_d   = 1'b1;
        addr_d = BASE_ADDR + 9'd1;
        data_d = {24'b0, SCORE_X};
      end
      WR_Y: begin
        cs_d   = 1'b1;
        addr_d = BASE_ADDR + 9'd2;
        data_d = {24'b0, SCORE_Y};
      end
      default: begin
        cs_d   = 1'b0;
        addr_d = '0;
        data_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      chipselect <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      chipselect <= cs_d;
      address    <= addr_d;
      writedata  <= data_d;
      busy       <= cs_d;
    end
  end

  assign write = chipselect;

endmodule

// File: tb/tb_score_writer.sv
// Directed and randomized checks of score_writer against a score/burst model
// built from plain integer arithmetic.
module tb_score_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;

  logic        vsync = 1'b1, run = 1'b0, clr = 1'b0;
  logic        chipselect, write, busy;
  logic [8:0]  address;
  logic [31:0] writedata;
  logic [15:0] score_bcd;

  logic        vsync2 = 1'b1, run2 = 1'b0, clr2 = 1'b0;
  logic        cs2, wr2, busy2;
  logic [8:0]  addr2;
  logic [31:0] data2;
  logic [15:0] score2;

  int vectors = 0;
  int miscompares = 0;
  int m_score = 0;
  int m_fc = 0;
  int m2 = 0;
  int rem = 0;

  always #10 clk = ~clk;

  score_writer dut (
    .clk(clk), .reset_n(reset_n), .vsync(vsync), .run(run), .clr(clr),
    .chipselect(chipselect), .write(write), .address(address),
    .writedata(writedata), .score_bcd(score_bcd), .busy(busy)
  );

  score_writer #(
    .FRAMES_PER_POINT(1), .SCORE_X(8'd3), .SCORE_Y(8'd200), .BASE_ADDR(9'd100)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .vsync(vsync2), .run(run2), .clr(clr2),
    .chipselect(cs2), .write(wr2), .address(addr2),
    .writedata(data2), .score_bcd(score2), .busy(busy2)
  );

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 1000 % 10), 4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10)};
  endfunction

  function automatic int inc_score(input int s);
`ifdef SCORE_SATURATE_EN
    return (s == 9999) ? 9999 : s + 1;
`else
    return (s + 1) % 10000;
`endif
  endfunction

  function automatic logic [63:0] wr_pack(input logic cs, input logic wr, input logic bz,
                                          input logic [8:0] a, input logic [31:0] d);
    return {20'b0, cs, wr, bz, a, d};
  endfunction

  function automatic logic [63:0] exp2(input int r, input int s);
    case (r)
      3:       return wr_pack(1'b1, 1'b1, 1'b1, 9'd100, 32'(s % 10));
      2:       return wr_pack(1'b1, 1'b1, 1'b1, 9'd101, 32'd3);
      1:       return wr_pack(1'b1, 1'b1, 1'b1, 9'd102, 32'd200);
      default: return 64'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_tick(input logic r, input logic c);
    if (c) begin
      m_score = 0;
      m_fc    = 0;
    end else if (r) begin
      m_fc++;
      if (m_fc == 6) begin
        m_fc    = 0;
        m_score = inc_score(m_score);
      end
    end
  endtask

  // One vsync falling edge followed by a full check of the write burst.
  task automatic do_frame(input logic r, input logic c);
    @(negedge clk);
    run = r; clr = c; vsync = 1'b0;
    model_tick(r, c);
    @(negedge clk);
    clr = 1'b0;
    check("score", {48'b0, score_bcd}, {48'b0, to_bcd(m_score)});
    check("wr_digit", {20'b0, chipselect, write, busy, address, writedata},
          wr_pack(1'b1, 1'b1, 1'b1, 9'd10, 32'(m_score % 10)));
    @(negedge clk);
    check("wr_x", {20'b0, chipselect, write, busy, address, writedata},
          wr_pack(1'b1, 1'b1, 1'b1, 9'd11, 32'd8));
    @(negedge clk);
    check("wr_y", {20'b0, chipselect, write, busy, address, writedata},
          wr_pack(1'b1, 1'b1, 1'b1, 9'd12, 32'd8));
    @(negedge clk);
    check("idle", {20'b0, chipselect, write, busy, address, writedata}, 64'd0);
    vsync = 1'b1;
  endtask

  initial begin
    logic tk;
    // Asynchronous reset, observed before any clock edge
    #3 reset_n = 1'b0;
    #2;
    check("reset_outs", {20'b0, chipselect, write, busy, address, writedata}, 64'd0);
    check("reset_score", {48'b0, score_bcd}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle", {63'b0, chipselect}, 64'd0);

    // Six frames give the first point
    repeat (6) do_frame(1'b1, 1'b0);
    check("first_point", {48'b0, score_bcd}, 64'h0001);

    // Count up to 9, then one more point carries into the tens digit
    repeat (48) do_frame(1'b1, 1'b0);
    check("score_9", {48'b0, score_bcd}, 64'h0009);
    repeat (6) do_frame(1'b1, 1'b0);
    check("carry_10", {48'b0, score_bcd}, 64'h0010);

    // Clear coincident with the incrementing tick
    repeat (5) do_frame(1'b1, 1'b0);
    do_frame(1'b1, 1'b1);
    check("clr_wins", {48'b0, score_bcd}, 64'h0000);

    // run=0: score holds, bursts continue
    repeat (3) do_frame(1'b1, 1'b0);
    repeat (10) do_frame(1'b0, 1'b0);

    // Randomized run and clear
    repeat (80) do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));

    // Reset in the WR_X cycle aborts the burst
    @(negedge clk);
    run = 1'b1; vsync = 1'b0;
    model_tick(1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    vsync = 1'b1;
    check("pre_abort_wr_x", {20'b0, chipselect, write, busy, address, writedata},
          wr_pack(1'b1, 1'b1, 1'b1, 9'd11, 32'd8));
    #2 reset_n = 1'b0;
    #1;
    check("abort_outs", {20'b0, chipselect, write, busy, address, writedata}, 64'd0);
    check("abort_score", {48'b0, score_bcd}, 64'd0);
    m_score = 0;
    m_fc    = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_write_after_reset", {63'b0, chipselect}, 64'd0);
    end
    repeat (7) do_frame(1'b1, 1'b0);
    check("recover_point", {48'b0, score_bcd}, 64'h0001);

    // Second instance: a point per tick, ticks every other cycle
    run2 = 1'b1;
    for (int i = 0; i < 19998; i++) begin
      @(negedge clk);
      if (i < 24) check("burst2", {20'b0, cs2, wr2, busy2, addr2, data2}, exp2(rem, m2));
      vsync2 = ~vsync2;
      tk = ~vsync2;
      if (tk) m2 = inc_score(m2);
      if (rem > 0) rem--;
      else if (tk) rem = 3;
    end
    @(negedge clk);
    check("score_9999", {48'b0, score2}, 64'h9999);
    vsync2 = 1'b0;
    m2 = inc_score(m2);
    @(negedge clk);
    vsync2 = 1'b1;
`ifdef SCORE_SATURATE_EN
    check("wrap_or_hold", {48'b0, score2}, 64'h9999);
`else
    check("wrap_or_hold", {48'b0, score2}, 64'h0000);
`endif
    check("wrap_model", {48'b0, score2}, {48'b0, to_bcd(m2)});
    repeat (2) do_frame(1'b1, 1'b0);
    @(negedge clk);
    clr2 = 1'b1;
    @(negedge clk);
    clr2 = 1'b0;
    check("clr2", {48'b0, score2}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/score_writer.md
SCORE_WRITER -- requirements
Module: score_writer

Interface
REQ-001 Parameter FRAMES_PER_POINT, default 6: number of frame ticks per score increment; legal range 1..255.
REQ-002 Parameter SCORE_X, default 8'd8: score overlay column written to the display register.
REQ-003 Parameter SCORE_Y, default 8'd8: score overlay row written to the display register.
REQ-004 Parameter BASE_ADDR, default 9'd10: display register address of the score digit; X is at BASE_ADDR+1 and Y at BASE_ADDR+2.
REQ-005 clk  in  1  single clock, the same 50 MHz clock used by the display block.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 vsync  in  1  VGA vertical sync, active-low, synchronous to clk.
REQ-008 run  in  1  high while the game is running; enables scoring.
REQ-009 clr  in  1  synchronous score clear, one-cycle pulse.
REQ-010 chipselect  out  1  register-write strobe towards the display block.
REQ-011 write  out  1  write enable; always equal to chipselect.
REQ-012 address  out  9  display register address.
REQ-013 writedata  out  32  write data, zero-extended.
REQ-014 score_bcd  out  16  current score as 4 BCD digits; [3:0] is the ones digit.
REQ-015 busy  out  1  high while a write burst is in progress.

Function
REQ-016 Frame tick: vsync_q registers vsync; tick = vsync_q & ~vsync, so the tick is high for exactly one cycle per falling edge of vsync.
REQ-017 Frame counter: 8-bit. On tick with run=1 it increments. When it equals FRAMES_PER_POINT-1 it wraps to 0 and the score increments in the same cycle.
REQ-018 With run=0 the frame counter and the score hold.
REQ-019 BCD increment: the ones digit counts 0..9, and each digit carries into the next on 9->0.
REQ-020 9999+1: wraps to 0000, or saturates per REQ-030.
REQ-021 clr=1 sets the score and the frame counter to 0 on the next edge. clr wins over a coincident increment.
REQ-022 FSM states are IDLE, WR_DIGIT, WR_X and WR_Y. IDLE->WR_DIGIT on tick, regardless of run. Each WR state advances unconditionally: WR_DIGIT->WR_X->WR_Y->IDLE.
REQ-023 Registered outputs per state:
- WR_DIGIT: chipselect=write=1, address=BASE_ADDR, writedata={28'b0, score_bcd[3:0]}.
- WR_X: chipselect=write=1, address=BASE_ADDR+1, writedata={24'b0, SCORE_X}.
- WR_Y: chipselect=write=1, address=BASE_ADDR+2, writedata={24'b0, SCORE_Y}.
- IDLE: chipselect=write=0, address=0, writedata=0.
REQ-024 Latency: for a tick in cycle t, the writes appear in cycles t+1, t+2 and t+3. The WR_DIGIT data reflects any score update or clear taken at the end of cycle t.
REQ-025 A tick while busy=1 still updates the counters but does not restart or extend the burst.
REQ-026 busy=1 exactly in WR_DIGIT, WR_X and WR_Y. No two bursts overlap, and exactly 3 write cycles occur per burst.
REQ-027 score_bcd is a registered output that changes only on increment, clear or reset.

Reset
REQ-028 reset_n=0 immediately forces the following, asynchronously:
- state=IDLE
- score_bcd=0 and frame counter=0
- vsync_q=1
- chipselect=0, write=0, address=0, writedata=0, busy=0
REQ-029 Reset asserted mid-burst aborts the burst with no further write cycles. After release, no write occurs until the next vsync falling edge.

Configuration
REQ-030 Macro SCORE_SATURATE_EN:
- Defined: the score holds at 9999 on further increments.
- Undefined: the score wraps 9999->0000.
- clr behaves identically in both builds.

Structure
REQ-031 Package score_pkg holds:
- typedef wr_state_t for the FSM states
- constants SCORE_ADDR=9'd10, SCORE_X_ADDR=9'd11, SCORE_Y_ADDR=9'd12
- BCD digit width and maximum value (4'd9)
REQ-032 One sub-module, bcd_digit, implements a single 4-bit digit with inc_in, clr, carry_out and (under SCORE_SATURATE_EN) a saturate input. score_writer instantiates four of them.

Verification
REQ-033 Reset, then 6 vsync falling edges with run=1 and default parameters -> score_bcd=0x0001. The burst after the 6th edge writes addr 10/11/12 with data 1/8/8 in 3 consecutive cycles.
REQ-034 score_bcd=0x0009, then an increment -> score_bcd=0x0010 and writedata on the digit write is 0.
REQ-035 score_bcd=0x9999, then an increment -> 0x0000 without the macro, 0x9999 with SCORE_SATURATE_EN.
REQ-036 clr on the tick cycle of an increment -> score_bcd=0x0000 and the next digit write carries data 0.
REQ-037 run=0 for 10 frames -> score is unchanged, and exactly 10 bursts of 3 writes each are issued.
REQ-038 reset_n pulled low in the WR_X cycle -> chipselect=0 immediately, and no WR_Y cycle is issued.
